// File: rtl/hazard_scoreboard.sv
// Hazard, flush and forwarding controller for the 5-stage pipeline.
// Also tracks long-latency writers in a scoreboard and keeps saturating perf counters.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MAX_OUT  = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           id_valid,
    input  logic [REG_AW-1:0]              id_rs1,
    input  logic [REG_AW-1:0]              id_rs2,
    input  logic                           id_uses_rs1,
    input  logic                           id_uses_rs2,
    input  logic [REG_AW-1:0]              id_rd,
    input  logic                           id_reg_write,
    input  logic                           id_long,
    input  logic                           ex_valid,
    input  logic                           ex_mem_read,
    input  logic                           ex_reg_write,
    input  logic [REG_AW-1:0]              ex_rs1,
    input  logic [REG_AW-1:0]              ex_rs2,
    input  logic [REG_AW-1:0]              ex_rd,
    input  logic                           ex_redirect,
    input  logic                           mem_reg_write,
    input  logic [REG_AW-1:0]              mem_rd,
    input  logic                           wb_reg_write,
    input  logic [REG_AW-1:0]              wb_rd,
    input  logic                           lu_done,
    input  logic [REG_AW-1:0]              lu_rd,
    output logic                           stall_if,
    output logic                           stall_id,
    output logic                           flush_id,
    output logic                           flush_ex,
    output logic [1:0]                     forward_a,
    output logic [1:0]                     forward_b,
    output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
    output logic                           sb_err,
    output logic [CNT_W-1:0]               stall_cnt,
    output logic [CNT_W-1:0]               flush_cnt
);

    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [OW-1:0]       outst_q, outst_d;
    logic                sb_err_q, sb_err_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic                load_use_c, raw_c, waw_c, struct_c, hz_c, issue_c;
    logic                inc_c, dec_c;
    // A load in EX always writes rd, so the EX write enable adds nothing here.
    logic                unused_ex_reg_write;

    assign unused_ex_reg_write = ex_reg_write;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_dst,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_dst
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_we && (mem_dst != '0) && (mem_dst == rs)) begin
            sel = 2'b01;
        end else if (wb_we && (wb_dst != '0) && (wb_dst == rs)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    // ID hazard detection; no lu_done bypass into the same cycle.
    always_comb begin
        load_use_c = ex_valid && ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));
        raw_c      = (id_uses_rs1 && pending_q[id_rs1]) ||
                     (id_uses_rs2 && pending_q[id_rs2]);
        waw_c      = id_reg_write && pending_q[id_rd];
        struct_c   = id_long && (outst_q == OW'(MAX_OUT));
        hz_c       = id_valid && (load_use_c || raw_c || waw_c || struct_c);
        issue_c    = id_valid && !hz_c && !ex_redirect;
    end

    // Pipeline control: redirect kills ID, so it outranks any ID hazard.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (reset) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else begin
            if (ex_redirect) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (hz_c) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
            forward_a = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
            forward_b = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (issue_c && id_long && id_reg_write && (id_rd != '0)) begin
            pending_d[id_rd] = 1'b1;
        end
        if (lu_done) begin
            pending_d[lu_rd] = 1'b0;
        end
        pending_d[0] = 1'b0;

        inc_c   = issue_c && id_long;
        dec_c   = lu_done && (outst_q != '0);
        outst_d = outst_q;
        case ({inc_c, dec_c})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        sb_err_d = sb_err_q || (lu_done && (!pending_q[lu_rd] || (outst_q == '0)));

        stall_cnt_d = stall_cnt_q;
        if (stall_id && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (ex_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            outst_q     <= '0;
            sb_err_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            outst_q     <= outst_d;
            sb_err_q    <= sb_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign outstanding = outst_q;
    assign sb_err      = sb_err_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-cycle expectations queued when driven,
// popped and compared at the falling edge.
module tb_hazard_scoreboard;

    localparam int unsigned NR  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned MO  = 2;
    localparam int unsigned CW  = 3;
    localparam int unsigned OW  = $clog2(MO + 1);
    localparam int          SAT = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_long;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          ex_valid, ex_mem_read, ex_reg_write, ex_redirect;
    logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic          mem_reg_write, wb_reg_write, lu_done;
    logic [AW-1:0] mem_rd, wb_rd, lu_rd;
    logic          stall_if, stall_id, flush_id, flush_ex, sb_err;
    logic [1:0]    forward_a, forward_b;
    logic [OW-1:0] outstanding;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct {
        string tag;
        int    stl;
        int    fid;
        int    fex;
        int    fa;
        int    fb;
        int    outst;
        int    err;
        int    scnt;
        int    fcnt;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_scnt = 0;
    int   exp_fcnt = 0;

    hazard_scoreboard #(
        .NUM_REGS(NR), .REG_AW(AW), .MAX_OUT(MO), .CNT_W(CW)
    ) u_dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_long(id_long),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .lu_done(lu_done), .lu_rd(lu_rd),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
        .forward_a(forward_a), .forward_b(forward_b), .outstanding(outstanding),
        .sb_err(sb_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard consumer plus the no-same-register set/clear invariant.
    always @(negedge clk) begin
        if (expq.size() != 0) begin
            cur = expq.pop_front();
            check_eq({cur.tag, ".stall_if"},  32'(stall_if),    cur.stl);
            check_eq({cur.tag, ".stall_id"},  32'(stall_id),    cur.stl);
            check_eq({cur.tag, ".flush_id"},  32'(flush_id),    cur.fid);
            check_eq({cur.tag, ".flush_ex"},  32'(flush_ex),    cur.fex);
            check_eq({cur.tag, ".forward_a"}, 32'(forward_a),   cur.fa);
            check_eq({cur.tag, ".forward_b"}, 32'(forward_b),   cur.fb);
            check_eq({cur.tag, ".outst"},     32'(outstanding), cur.outst);
            check_eq({cur.tag, ".sb_err"},    32'(sb_err),      cur.err);
            check_eq({cur.tag, ".stall_cnt"}, 32'(stall_cnt),   cur.scnt);
            check_eq({cur.tag, ".flush_cnt"}, 32'(flush_cnt),   cur.fcnt);
        end
        if (!reset) begin
            check_eq("set_clr_same_reg",
                     32'(id_valid && !stall_id && !ex_redirect && id_long && id_reg_write &&
                         (id_rd != '0) && lu_done && (lu_rd == id_rd)), 0);
        end
    end

    task automatic idle();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_reg_write = 0; id_long = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0; ex_redirect = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        mem_reg_write = 0; mem_rd = 0; wb_reg_write = 0; wb_rd = 0;
        lu_done = 0; lu_rd = 0;
    endtask

    // Queue this cycle's expectation, let it be checked, then advance the counter model.
    task automatic step(input string tag, input int stl, input int fid, input int fex,
                        input int fa, input int fb, input int outst, input int err);
        exp_t e;
        e.tag = tag; e.stl = stl; e.fid = fid; e.fex = fex; e.fa = fa; e.fb = fb;
        e.outst = outst; e.err = err; e.scnt = exp_scnt; e.fcnt = exp_fcnt;
        expq.push_back(e);
        @(negedge clk);
        if (reset) begin
            exp_scnt = 0;
            exp_fcnt = 0;
        end else begin
            if (stl != 0 && exp_scnt < SAT) exp_scnt++;
            if (ex_redirect && exp_fcnt < SAT) exp_fcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles; the second checks reset outputs with live forwarding inputs.
    task automatic do_reset();
        idle();
        reset = 1;
        mem_reg_write = 1; mem_rd = 3; ex_rs1 = 3; ex_rs2 = 3;
        @(posedge clk);
        #1;
        exp_scnt = 0;
        exp_fcnt = 0;
        step("rst", 0, 1, 1, 0, 0, 0, 0);
        reset = 0;
        idle();
    endtask

    task automatic load_use_setup();
        ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5;
        id_valid = 1; id_rs1 = 5; id_uses_rs1 = 1; id_rs2 = 1; id_uses_rs2 = 1;
        id_rd = 6; id_reg_write = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1;

        // Load-use: one stall cycle.
        do_reset();
        load_use_setup();
        step("lu_stall", 1, 0, 1, 0, 0, 0, 0);
        ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
        step("lu_go", 0, 0, 0, 0, 0, 0, 0);
        check_eq("lu_stall_cnt", 32'(stall_cnt), 1);

        // Long RAW: div x7, consumer stalls through the lu_done cycle.
        do_reset();
        id_valid = 1; id_long = 1; id_reg_write = 1; id_rd = 7;
        step("div_issue", 0, 0, 0, 0, 0, 0, 0);
        id_long = 0; id_rd = 8; id_rs1 = 7; id_uses_rs1 = 1;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) begin
                lu_done = 1; lu_rd = 7;
            end
            step("raw_wait", 1, 0, 1, 0, 0, 1, 0);
        end
        lu_done = 0;
        step("raw_go", 0, 0, 0, 0, 0, 0, 0);
        check_eq("raw_stall_cnt", 32'(stall_cnt), 6);
        check_eq("raw_outst", 32'(outstanding), 0);

        // Redirect beats load-use; the killed long op sets nothing.
        do_reset();
        load_use_setup();
        ex_redirect = 1; id_long = 1; id_rd = 9;
        step("redir", 0, 1, 1, 0, 0, 0, 0);
        idle();
        id_valid = 1; id_rs1 = 9; id_uses_rs1 = 1; id_rd = 6; id_reg_write = 1;
        step("redir_nopend", 0, 0, 0, 0, 0, 0, 0);
        check_eq("redir_flush_cnt", 32'(flush_cnt), 1);
        check_eq("redir_stall_cnt", 32'(stall_cnt), 0);

        // Structural: MAX_OUT=2, third long op waits for the first completion.
        do_reset();
        id_valid = 1; id_long = 1; id_reg_write = 1;
        id_rd = 8;  step("long_x8", 0, 0, 0, 0, 0, 0, 0);
        id_rd = 9;  step("long_x9", 0, 0, 0, 0, 0, 1, 0);
        id_rd = 10; step("full", 1, 0, 1, 0, 0, 2, 0);
        lu_done = 1; lu_rd = 8;
        step("full_done", 1, 0, 1, 0, 0, 2, 0);
        lu_done = 0;
        step("long_x10", 0, 0, 0, 0, 0, 1, 0);
        idle();
        step("full_again", 0, 0, 0, 0, 0, 2, 0);
        lu_done = 1; lu_rd = 9;
        step("done_x9", 0, 0, 0, 0, 0, 2, 0);
        lu_rd = 10;
        step("done_x10", 0, 0, 0, 0, 0, 1, 0);
        idle();
        id_valid = 1; id_rs1 = 10; id_uses_rs1 = 1;
        step("drained", 0, 0, 0, 0, 0, 0, 0);
        check_eq("struct_stall_cnt", 32'(stall_cnt), 2);

        // Forwarding priority and x0 exclusion.
        do_reset();
        mem_reg_write = 1; wb_reg_write = 1; mem_rd = 3; wb_rd = 3; ex_rs1 = 3; ex_rs2 = 3;
        step("fw_mem", 0, 0, 0, 1, 1, 0, 0);
        mem_reg_write = 0;
        step("fw_wb", 0, 0, 0, 2, 2, 0, 0);
        ex_rs1 = 0;
        step("fw_x0", 0, 0, 0, 0, 2, 0, 0);
        mem_reg_write = 1; mem_rd = 4; ex_rs1 = 3; ex_rs2 = 4;
        step("fw_mix", 0, 0, 0, 2, 1, 0, 0);
        mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
        step("fw_zero", 0, 0, 0, 0, 0, 0, 0);

        // Spurious completion sets sticky error; stall counter saturates.
        do_reset();
        lu_done = 1; lu_rd = 4;
        step("bad_done", 0, 0, 0, 0, 0, 0, 0);
        lu_done = 0;
        load_use_setup();
        for (int c = 0; c < 10; c++) begin
            step("sat", 1, 0, 1, 0, 0, 0, 1);
        end
        idle();
        step("sat_end", 0, 0, 0, 0, 0, 0, 1);
        check_eq("sat_stall_cnt", 32'(stall_cnt), 7);
        check_eq("err_sticky", 32'(sb_err), 1);
        do_reset();
        check_eq("err_cleared", 32'(sb_err), 0);

        // Reset mid-flight discards the op; its late completion is an error.
        id_valid = 1; id_long = 1; id_reg_write = 1; id_rd = 11;
        step("mo_issue", 0, 0, 0, 0, 0, 0, 0);
        idle();
        step("mo_pend", 0, 0, 0, 0, 0, 1, 0);
        do_reset();
        lu_done = 1; lu_rd = 11;
        step("mo_stale", 0, 0, 0, 0, 0, 0, 0);
        lu_done = 0;
        step("mo_err", 0, 0, 0, 0, 0, 0, 1);

        check_eq("queue_drained", 32'(expq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard, flush and forwarding controller for the 5-stage RISC-V pipeline. It handles single-cycle ALU forwarding and load-use stalls, and adds three things:
- a register scoreboard for variable-latency execution units (mul/div),
- branch/jump redirect flushing,
- saturating performance counters.

It sits beside the IF/ID and ID/EX pipeline registers and drives their stall and flush inputs, and drives the EX forwarding muxes.

## Interface
- NUM_REGS, 32, architectural register count (x0 hardwired zero)
- REG_AW, 5, register address width (clog2 of NUM_REGS)
- MAX_OUT, 4, maximum outstanding long-latency ops (1..15)
- CNT_W, 16, performance counter width
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW  ID source registers
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- id_rd  in  REG_AW  ID destination
- id_reg_write  in  1  ID writes rd
- id_long  in  1  ID instruction issues to the long-latency unit
- ex_valid, ex_mem_read, ex_reg_write  in  1  EX-stage controls
- ex_rs1, ex_rs2, ex_rd  in  REG_AW  EX-stage registers
- ex_redirect  in  1  taken branch or jump resolved in EX
- mem_reg_write  in  1 / mem_rd  in  REG_AW  MEM-stage writer
- wb_reg_write  in  1 / wb_rd  in  REG_AW  WB-stage writer
- lu_done  in  1 / lu_rd  in  REG_AW  long unit completes; writes the register file this cycle
- stall_if, stall_id  out  1  hold PC and IF/ID
- flush_id  out  1  zero IF/ID (bubble)
- flush_ex  out  1  zero ID/EX (bubble)
- forward_a, forward_b  out  2  00 register file, 01 MEM ALU result, 10 WB result
- outstanding  out  clog2(MAX_OUT+1)  long ops in flight
- sb_err  out  1  sticky: lu_done for a non-pending register
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- State:
  - pending[NUM_REGS-1:0]; pending[0] is never set.
  - outstanding counter.
  - sb_err.
  - the two perf counters.
- ID hazard term `hz` (combinational, only when id_valid):
  - load-use: ex_valid & ex_mem_read & ex_rd≠0 & (uses_rs1 & rs1==ex_rd | uses_rs2 & rs2==ex_rd).
  - RAW: pending[rs1] & uses_rs1, or pending[rs2] & uses_rs2.
  - WAW: id_reg_write & pending[id_rd].
  - structural: id_long & outstanding==MAX_OUT.
- Output priority:
  1. If ex_redirect: flush_id=flush_ex=1, stall_if=stall_id=0. The redirect wins over hz because the ID instruction is killed.
  2. Else if hz: stall_if=stall_id=1, flush_ex=1, flush_id=0.
  3. Else: all 0.
- Issue = id_valid & ~hz & ~ex_redirect.
- Scoreboard set: issue & id_long & id_reg_write & id_rd≠0 sets pending[id_rd].
- outstanding increments on issue & id_long, independent of rd. It decrements on lu_done when nonzero. Simultaneous increment and decrement leaves it unchanged.
- lu_done clears pending[lu_rd].
  - If pending[lu_rd]==0, or outstanding==0, set sb_err. sb_err clears only on reset.
  - Set and clear of the same register in one cycle cannot occur: WAW stalls issue against a pending rd. The bench asserts this.
- Forwarding (combinational, for EX sources; same rule for forward_b):
  - forward_a=01 if mem_reg_write & mem_rd≠0 & mem_rd==ex_rs1.
  - else 10 if wb_reg_write & wb_rd≠0 & wb_rd==ex_rs1.
  - else 00.
  - MEM has priority over WB.
- Counters, each saturating at 2^CNT_W−1:
  - stall_cnt +1 per cycle with stall_id=1.
  - flush_cnt +1 per cycle with ex_redirect=1.

## Timing
- Reset (synchronous):
  - pending=0, outstanding=0, sb_err=0, counters=0.
  - While reset is high: flush_id=flush_ex=1, stall_if=stall_id=0, forward_a=forward_b=00.
- Reset mid-operation discards all in-flight scoreboard state. A later lu_done for a discarded op raises sb_err.
- Stall, flush and forward outputs are combinational with zero latency. State updates at the next rising edge.
- Long op issued in cycle N: pending is visible in N+1, so a dependent instruction in ID at N+1 stalls.
- lu_done in cycle M: pending clears at the M/M+1 edge, and the dependent instruction issues in M+1. The register file must be write-first or written in M.
- No bypass of lu_done into the same-cycle hazard check. The stall persists through cycle M.
- outstanding==MAX_OUT with lu_done in the same cycle: the ID long op still stalls that cycle.

## Test plan
- Load-use: EX lw x5 (ex_mem_read=1, ex_rd=5), ID add x6,x5,x1 → stall_if=stall_id=flush_ex=1 for one cycle; stall_cnt=1.
- Long RAW: issue div x7 at cycle 0, ID uses x7 from cycle 1, lu_done with lu_rd=7 at cycle 6 → stall cycles 1–6, issue at 7; outstanding 1→0; stall_cnt=6.
- Redirect over hazard: load-use condition plus ex_redirect=1 → flush_id=flush_ex=1, stall_id=0, no pending set, flush_cnt=1.
- Structural: MAX_OUT=2, two long ops to x8 and x9 issued, third long op in ID → stalls until the first lu_done, then issues the next cycle; outstanding never exceeds 2.
- Forwarding: ex_rs1=3, mem_rd=3, wb_rd=3, both writes on → forward_a=01. With mem_reg_write=0 → 10. With ex_rs1=0 → 00.
- Error and saturation: lu_done with lu_rd=4 while not pending → sb_err=1, held until reset. CNT_W=3 with 10 stall cycles → stall_cnt=7.
